xcvr_pattern_checker_sequencer: RTL and testbench
=================================================

// Module: xcvr_pattern_checker_sequencer
// PURPOSE
//  Avalon-MM master that sequences one data pattern checker through its CSR slave.
//  Per run: program pattern, enable, wait for lock, then periodically snapshot and read 64-bit error/bit counters.
//  Flags fail on an error threshold; disables the checker on stop.
//  Sits beside the checker in the xcvr test system; replaces software polling.
// PARAMETERS
//  POLL_INTERVAL  1024    cycles between counter snapshots in RUN (>=1)
//  READ_LATENCY   1       cycles from read strobe to valid avm_readdata (1..3)
//  LOCK_TIMEOUT   65535   WAIT_LOCK cycle limit (used only with XCVR_CHK_SEQ_TIMEOUT_EN)
// PORTS
//  csr_clk_clk     in   1   single clock
//  reset_reset     in   1   async active-high reset
//  start           in   1   pulse: begin run (ignored unless IDLE)
//  stop            in   1   pulse: end run (ignored in IDLE/DISABLE)
//  pattern_sel     in   3   pattern code, sampled on accepted start
//  err_threshold   in   32  fail when error_count > threshold, sampled on start
//  avm_address     out  3   checker CSR word address
//  avm_write       out  1   one-cycle write strobe
//  avm_read        out  1   one-cycle read strobe
//  avm_byteenable  out  4   always 4'hF while strobing, else 0
//  avm_writedata   out  32  write data
//  avm_readdata    in   32  read data, valid READ_LATENCY cycles after avm_read
//  busy            out  1   high in any state but IDLE
//  locked          out  1   checker lock seen this run
//  error_count     out  64  last snapshot error count
//  bit_count       out  64  last snapshot bit count
//  sample_valid    out  1   one-cycle pulse when both counts updated
//  fail            out  1   sticky until next accepted start
//  lock_timeout    out  1   sticky until next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/timers 0.
//  CSR map (package constants): 0 CTRL{b2 snap, b1 clr, b0 en}, 1 STATUS{b0 lock}, 2 PATSEL[2:0],
//   3 ERR_LO, 4 ERR_HI, 5 BITS_LO, 6 BITS_HI.
//  One bus access at a time. Write = 1-cycle strobe.
//  Read = 1-cycle strobe, then capture readdata exactly READ_LATENCY cycles later. No waitrequest.
//  FSM:
//   IDLE -start-> CFG_PAT: wr PATSEL=pattern_sel.
//   -> CLR_EN: wr CTRL=3'b011.
//   -> EN: wr CTRL=3'b001.
//   -> WAIT_LOCK: rd STATUS each access.
//    lock=1 -> set locked, go RUN.
//   RUN: count POLL_INTERVAL cycles -> SNAP: wr CTRL=3'b101.
//   SNAP -> RD_ELO -> RD_EHI -> RD_BLO -> RD_BHI: reads into shadow regs.
//   UPDATE (1 cycle): copy shadows to error_count/bit_count; pulse sample_valid;
//    fail|=(error_count>{32'b0,err_threshold}); -> RUN.
//   DISABLE: wr CTRL=0 -> IDLE.
//  Stop: latched as pending in any non-IDLE state.
//   The in-flight access (incl. read latency) completes first; then go DISABLE.
//   A partial snapshot is discarded: no UPDATE, no sample_valid.
//  start and stop in the same IDLE cycle: stop wins, no run.
//  Start while busy: ignored.
//  Interval counter: reloads on RUN entry; counts POLL_INTERVAL-1 down to 0; no wrap.
//  Lock drop in RUN is not monitored; locked holds until next start.
//  Reset mid-run: strobes drop immediately. The checker is not disabled, so software must re-run.
// CONFIGURATION
//  XCVR_CHK_SEQ_TIMEOUT_EN defined:
//   WAIT_LOCK counter hits LOCK_TIMEOUT -> set lock_timeout, go DISABLE.
//  Undefined:
//   no timeout counter; WAIT_LOCK polls until lock or stop; lock_timeout tied 0.
// STRUCTURE
//  Package xcvr_chk_seq_pkg: CSR address localparams, CTRL bit positions, state enum typedef.
//  Sub-module xcvr_avmm_access: single-access Avalon-MM engine.
//   Interface: req/wr/addr/wdata in -> done/rdata out; owns READ_LATENCY pipeline.
//   The FSM issues one req per state and advances on done.
// TESTING
//  T1 start, pattern_sel=3, checker BFM locks on 2nd STATUS read:
//   writes PATSEL=3, CTRL=3, CTRL=1; locked=1 after 2nd read.
//  T2 POLL_INTERVAL=16, BFM ERR={0x1,0x0}, BITS={0x0,0x2}:
//   sample_valid pulse; error_count=64'h1_0000_0000; bit_count=64'h2.
//  T3 err_threshold=5, error_count=6: fail=1 on the UPDATE cycle and stays set.
//   Next start clears fail.
//  T4 stop asserted during RD_EHI: error_count unchanged; no sample_valid;
//   next access is a CTRL=0 write; busy=0 one cycle after it.
//  T5 with XCVR_CHK_SEQ_TIMEOUT_EN, LOCK_TIMEOUT=100, lock never asserted:
//   lock_timeout=1; CTRL=0 written; IDLE. Without the macro: still polling at cycle 1000.
//  T6 reset_reset asserted mid-SNAP: all outputs 0 asynchronously; start accepted after release.

Source files
------------

// File: rtl/xcvr_chk_seq_pkg.sv
// Shared definitions for the pattern-checker sequencer: checker CSR word
// addresses, CTRL/STATUS bit positions, the sequencer state encoding and a
// helper that builds CTRL write words.
package xcvr_chk_seq_pkg;

    // Checker CSR word addresses
    localparam logic [2:0] CSR_CTRL    = 3'd0;
    localparam logic [2:0] CSR_STATUS  = 3'd1;
    localparam logic [2:0] CSR_PATSEL  = 3'd2;
    localparam logic [2:0] CSR_ERR_LO  = 3'd3;
    localparam logic [2:0] CSR_ERR_HI  = 3'd4;
    localparam logic [2:0] CSR_BITS_LO = 3'd5;
    localparam logic [2:0] CSR_BITS_HI = 3'd6;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_SNAP_BIT   = 2;
    localparam int STATUS_LOCK_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_PAT,
        ST_CLR_EN,
        ST_EN,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_SNAP,
        ST_RD_ELO,
        ST_RD_EHI,
        ST_RD_BLO,
        ST_RD_BHI,
        ST_UPDATE,
        ST_DISABLE
    } chk_state_t;

    // Build a CTRL register write word from its individual control bits
    function automatic logic [31:0] ctrl_word(input logic snap, input logic clr, input logic en);
        logic [31:0] w;
        w                = '0;
        w[CTRL_SNAP_BIT] = snap;
        w[CTRL_CLR_BIT]  = clr;
        w[CTRL_EN_BIT]   = en;
        return w;
    endfunction

endpackage

// File: rtl/xcvr_avmm_access.sv
// Single-access Avalon-MM engine. A held req launches exactly one
// one-cycle read or write strobe; done marks completion. For writes done
// coincides with the strobe cycle, for reads it coincides with the cycle
// in which avm_readdata is valid (READ_LATENCY cycles after the strobe),
// and rdata is that readdata. No waitrequest handling: the slave is assumed
// to accept every strobe.
module xcvr_avmm_access #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    logic       active_reg;
    logic       is_read_reg;
    logic [1:0] lat_cnt_reg;

    // Completion: write finishes with its strobe, read when data is due
    assign done  = active_reg && (!is_read_reg || (lat_cnt_reg == LAT));
    assign rdata = avm_readdata;

    // Launch one strobe per idle request, then track read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg     <= 1'b0;
            is_read_reg    <= 1'b0;
            lat_cnt_reg    <= 2'd0;
            avm_address    <= 3'd0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'd0;
        end else begin
            avm_address    <= 3'd0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'd0;
            if (!active_reg) begin
                if (req) begin
                    active_reg     <= 1'b1;
                    is_read_reg    <= !wr;
                    lat_cnt_reg    <= 2'd0;
                    avm_address    <= addr;
                    avm_write      <= wr;
                    avm_read       <= !wr;
                    avm_byteenable <= 4'hF;
                    avm_writedata  <= wr ? wdata : 32'd0;
                end
            end else if (done) begin
                active_reg <= 1'b0;
            end else begin
                lat_cnt_reg <= lat_cnt_reg + 2'd1;
            end
        end
    end

endmodule

// File: rtl/xcvr_pattern_checker_sequencer.sv
// Avalon-MM master that runs one data pattern checker through its CSR
// slave: program pattern, clear+enable, wait for lock, then periodically
// snapshot and read the 64-bit error/bit counters, flagging fail when the
// error count exceeds the threshold. A stop disables the checker.
// Optional build macro XCVR_CHK_SEQ_TIMEOUT_EN adds a WAIT_LOCK timeout
// (LOCK_TIMEOUT cycles) that raises lock_timeout and disables the checker.
module xcvr_pattern_checker_sequencer
    import xcvr_chk_seq_pkg::*;
#(
    parameter int POLL_INTERVAL = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic        csr_clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  pattern_sel,
    input  logic [31:0] err_threshold,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        locked,
    output logic [63:0] error_count,
    output logic [63:0] bit_count,
    output logic        sample_valid,
    output logic        fail,
    output logic        lock_timeout
);

    chk_state_t  state_reg, state_next;

    logic        acc_req;
    logic        acc_wr;
    logic [2:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_done;
    logic [31:0] acc_rdata;

    logic        stop_pending_reg;
    logic [2:0]  pattern_reg;
    logic [31:0] threshold_reg;
    logic [31:0] err_lo_reg;
    logic [31:0] err_hi_reg;
    logic [31:0] bits_lo_reg;
    logic [63:0] error_count_reg;
    logic [63:0] bit_count_reg;
    logic        sample_valid_reg;
    logic        fail_reg;
    logic        locked_reg;
    logic [31:0] interval_cnt_reg;

    logic        start_accept;
    logic        stop_req;
    logic        lock_seen;
    logic        timeout_hit;

    // Stop beats start when both arrive in IDLE
    assign start_accept = (state_reg == ST_IDLE) && start && !stop;
    assign stop_req     = stop_pending_reg ||
                          (stop && (state_reg != ST_IDLE) && (state_reg != ST_DISABLE));
    assign lock_seen    = acc_done && acc_rdata[STATUS_LOCK_BIT];

`ifdef XCVR_CHK_SEQ_TIMEOUT_EN
    logic [31:0] lock_timer_reg;
    logic        lock_timeout_reg;

    assign timeout_hit  = (lock_timer_reg >= 32'(LOCK_TIMEOUT));
    assign lock_timeout = lock_timeout_reg;

    // Count WAIT_LOCK cycles (saturating) and flag the timeout when it ends the wait
    always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lock_timer_reg   <= 32'd0;
            lock_timeout_reg <= 1'b0;
        end else begin
            if (state_reg != ST_WAIT_LOCK) begin
                lock_timer_reg <= 32'd0;
            end else if (!timeout_hit) begin
                lock_timer_reg <= lock_timer_reg + 32'd1;
            end
            if (start_accept) begin
                lock_timeout_reg <= 1'b0;
            end else if (state_reg == ST_WAIT_LOCK && acc_done && !lock_seen &&
                         !stop_req && timeout_hit) begin
                lock_timeout_reg <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign lock_timeout = 1'b0;
`endif

    xcvr_avmm_access #(
        .READ_LATENCY (READ_LATENCY)
    ) u_access (
        .clk            (csr_clk_clk),
        .rst            (reset_reset),
        .req            (acc_req),
        .wr             (acc_wr),
        .addr           (acc_addr),
        .wdata          (acc_wdata),
        .done           (acc_done),
        .rdata          (acc_rdata),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    // State register
    always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-state bus request; access states advance only on done
    always_comb begin
        state_next = state_reg;
        acc_req    = 1'b0;
        acc_wr     = 1'b0;
        acc_addr   = 3'd0;
        acc_wdata  = 32'd0;
        case (state_reg)
            ST_IDLE: begin
                if (start_accept) state_next = ST_CFG_PAT;
            end
            ST_CFG_PAT: begin
                acc_req   = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = CSR_PATSEL;
                acc_wdata = {29'd0, pattern_reg};
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_CLR_EN;
            end
            ST_CLR_EN: begin
                acc_req   = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = CSR_CTRL;
                acc_wdata = ctrl_word(1'b0, 1'b1, 1'b1);
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_EN;
            end
            ST_EN: begin
                acc_req   = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = CSR_CTRL;
                acc_wdata = ctrl_word(1'b0, 1'b0, 1'b1);
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                acc_req  = 1'b1;
                acc_addr = CSR_STATUS;
                if (acc_done) begin
                    if (stop_req)         state_next = ST_DISABLE;
                    else if (lock_seen)   state_next = ST_RUN;
                    else if (timeout_hit) state_next = ST_DISABLE;
                end
            end
            ST_RUN: begin
                if (stop_req)                    state_next = ST_DISABLE;
                else if (interval_cnt_reg == 0)  state_next = ST_SNAP;
            end
            ST_SNAP: begin
                acc_req   = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = CSR_CTRL;
                acc_wdata = ctrl_word(1'b1, 1'b0, 1'b1);
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_RD_ELO;
            end
            ST_RD_ELO: begin
                acc_req  = 1'b1;
                acc_addr = CSR_ERR_LO;
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_RD_EHI;
            end
            ST_RD_EHI: begin
                acc_req  = 1'b1;
                acc_addr = CSR_ERR_HI;
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_RD_BLO;
            end
            ST_RD_BLO: begin
                acc_req  = 1'b1;
                acc_addr = CSR_BITS_LO;
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_RD_BHI;
            end
            ST_RD_BHI: begin
                acc_req  = 1'b1;
                acc_addr = CSR_BITS_HI;
                if (acc_done) state_next = stop_req ? ST_DISABLE : ST_UPDATE;
            end
            ST_UPDATE: begin
                state_next = stop_req ? ST_DISABLE : ST_RUN;
            end
            ST_DISABLE: begin
                acc_req   = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = CSR_CTRL;
                acc_wdata = 32'd0;
                if (acc_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run parameters, stop latch, interval timer, shadows and published results.
    // Results are registered on the RD_BHI->UPDATE edge so they are visible
    // during the UPDATE cycle itself.
    always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stop_pending_reg <= 1'b0;
            pattern_reg      <= 3'd0;
            threshold_reg    <= 32'd0;
            err_lo_reg       <= 32'd0;
            err_hi_reg       <= 32'd0;
            bits_lo_reg      <= 32'd0;
            error_count_reg  <= 64'd0;
            bit_count_reg    <= 64'd0;
            sample_valid_reg <= 1'b0;
            fail_reg         <= 1'b0;
            locked_reg       <= 1'b0;
            interval_cnt_reg <= 32'd0;
        end else begin
            sample_valid_reg <= 1'b0;

            if (state_reg == ST_IDLE || state_reg == ST_DISABLE) begin
                stop_pending_reg <= 1'b0;
            end else if (stop) begin
                stop_pending_reg <= 1'b1;
            end

            if (start_accept) begin
                pattern_reg   <= pattern_sel;
                threshold_reg <= err_threshold;
                fail_reg      <= 1'b0;
                locked_reg    <= 1'b0;
            end

            if (state_reg == ST_WAIT_LOCK && lock_seen) begin
                locked_reg <= 1'b1;
            end

            if (state_reg != ST_RUN && state_next == ST_RUN) begin
                interval_cnt_reg <= 32'(POLL_INTERVAL - 1);
            end else if (state_reg == ST_RUN && interval_cnt_reg != 32'd0) begin
                interval_cnt_reg <= interval_cnt_reg - 32'd1;
            end

            if (acc_done) begin
                if (state_reg == ST_RD_ELO) err_lo_reg  <= acc_rdata;
                if (state_reg == ST_RD_EHI) err_hi_reg  <= acc_rdata;
                if (state_reg == ST_RD_BLO) bits_lo_reg <= acc_rdata;
            end

            if (state_reg == ST_RD_BHI && state_next == ST_UPDATE) begin
                error_count_reg  <= {err_hi_reg, err_lo_reg};
                bit_count_reg    <= {acc_rdata, bits_lo_reg};
                sample_valid_reg <= 1'b1;
                if ({err_hi_reg, err_lo_reg} > {32'd0, threshold_reg}) begin
                    fail_reg <= 1'b1;
                end
            end
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign locked       = locked_reg;
    assign error_count  = error_count_reg;
    assign bit_count    = bit_count_reg;
    assign sample_valid = sample_valid_reg;
    assign fail         = fail_reg;

endmodule

// File: tb/tb_xcvr_pattern_checker_sequencer.sv
// Directed bench for xcvr_pattern_checker_sequencer with a small checker
// CSR model (configurable lock point, counter values, read latency).
module tb_xcvr_pattern_checker_sequencer;
    import xcvr_chk_seq_pkg::*;

    localparam int PI = 16;
    localparam int RL = 2;
    localparam int LT = 100;

    logic        clk;
    logic        reset_reset;
    logic        start;
    logic        stop;
    logic [2:0]  pattern_sel;
    logic [31:0] err_threshold;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        locked;
    logic [63:0] error_count;
    logic [63:0] bit_count;
    logic        sample_valid;
    logic        fail;
    logic        lock_timeout;

    xcvr_pattern_checker_sequencer #(
        .POLL_INTERVAL (PI),
        .READ_LATENCY  (RL),
        .LOCK_TIMEOUT  (LT)
    ) dut (
        .csr_clk_clk    (clk),
        .reset_reset    (reset_reset),
        .start          (start),
        .stop           (stop),
        .pattern_sel    (pattern_sel),
        .err_threshold  (err_threshold),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .locked         (locked),
        .error_count    (error_count),
        .bit_count      (bit_count),
        .sample_valid   (sample_valid),
        .fail           (fail),
        .lock_timeout   (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Checker model state
    int          lock_after;
    int          status_reads;
    logic [31:0] err_lo, err_hi, bits_lo, bits_hi;
    int          rd_count [8];
    int          sv_count;
    logic        pv [RL+1];
    logic [2:0]  pa [RL+1];
    logic [2:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_be [$];
    int          wq_cyc [$];
    int          popped_cyc;

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            CSR_STATUS:  return {31'd0, (lock_after != 0) && (status_reads >= lock_after)};
            CSR_ERR_LO:  return err_lo;
            CSR_ERR_HI:  return err_hi;
            CSR_BITS_LO: return bits_lo;
            CSR_BITS_HI: return bits_hi;
            default:     return 32'd0;
        endcase
    endfunction

    initial begin
        for (int i = 0; i <= RL; i++) begin
            pv[i] = 1'b0;
            pa[i] = 3'd0;
        end
        for (int i = 0; i < 8; i++) rd_count[i] = 0;
        sv_count = 0;
    end

    // Checker slave: log writes, answer reads exactly RL cycles after the strobe
    always @(negedge clk) begin
        for (int i = RL; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = avm_read;
        pa[0] = avm_address;
        if (avm_read) begin
            rd_count[avm_address]++;
            if (avm_address == CSR_STATUS) status_reads++;
        end
        if (avm_write) begin
            wq_addr.push_back(avm_address);
            wq_data.push_back(avm_writedata);
            wq_be.push_back(avm_byteenable);
            wq_cyc.push_back(cyc);
        end
        if (sample_valid) sv_count++;
        avm_readdata = pv[RL] ? reg_value(pa[RL]) : 32'hBAD0_0000;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_be.delete();
        wq_cyc.delete();
    endtask

    task automatic expect_write(input string tag, input logic [2:0] a, input logic [31:0] d);
        int n;
        logic [2:0]  ga;
        logic [31:0] gd;
        logic [3:0]  gb;
        n = 0;
        while (wq_addr.size() == 0 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_seen"}, 64'(wq_addr.size() != 0), 64'd1);
        if (wq_addr.size() != 0) begin
            ga = wq_addr.pop_front();
            gd = wq_data.pop_front();
            gb = wq_be.pop_front();
            popped_cyc = wq_cyc.pop_front();
            check({tag, "_addr"}, 64'(ga), 64'(a));
            check({tag, "_data"}, 64'(gd), 64'(d));
            check({tag, "_be"}, 64'(gb), 64'hF);
        end
    endtask

    logic prev_fail;

    task automatic wait_sample(input string tag);
        int n;
        n = 0;
        prev_fail = fail;
        while (!sample_valid && n < 100) begin
            prev_fail = fail;
            step();
            n++;
        end
        check({tag, "_sample_seen"}, 64'(sample_valid), 64'd1);
    endtask

    task automatic start_run(input logic [2:0] p, input logic [31:0] thr);
        pattern_sel   = p;
        err_threshold = thr;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int n;
    int cyc_lock;
    int cyc_sample;
    int sv_snap;
    int rd5_snap;

    initial begin
        reset_reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        pattern_sel = 3'd0;
        err_threshold = 32'd0;
        lock_after = 2;
        status_reads = 0;
        err_lo = 32'd0;
        err_hi = 32'd1;
        bits_lo = 32'd2;
        bits_hi = 32'd0;
        repeat (3) step();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_read", 64'(avm_read), 64'd0);
        check("rst_be", 64'(avm_byteenable), 64'd0);
        check("rst_err", error_count, 64'd0);
        check("rst_bits", bit_count, 64'd0);
        check("rst_flags", 64'({sample_valid, fail, locked, lock_timeout}), 64'd0);
        reset_reset = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // T1: programming sequence and lock on second STATUS read
        start_run(3'd3, 32'hFFFF_FFFF);
        check("t1_busy", 64'(busy), 64'd1);
        expect_write("t1_patsel", CSR_PATSEL, 32'd3);
        expect_write("t1_clr_en", CSR_CTRL, 32'd3);
        expect_write("t1_en", CSR_CTRL, 32'd1);
        check("t1_not_locked_yet", 64'(locked), 64'd0);
        n = 0;
        while (!locked && n < 100) begin step(); n++; end
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_status_reads", 64'(status_reads), 64'd2);
        cyc_lock = cyc;

        // T2: first snapshot; 0x1_0000_0000 also exceeds threshold 0xFFFFFFFF
        wait_sample("t2");
        cyc_sample = cyc;
        check("t2_sample_latency", 64'(cyc_sample - cyc_lock), 64'd34);
        check("t2_error_count", error_count, 64'h1_0000_0000);
        check("t2_bit_count", bit_count, 64'h2);
        check("t2_fail_hi_word", 64'(fail), 64'd1);
        expect_write("t2_snap", CSR_CTRL, 32'd5);
        check("t2_snap_latency", 64'(popped_cyc - cyc_lock), 64'(PI + 1));
        step();
        check("t2_pulse_width", 64'(sample_valid), 64'd0);

        // Second snapshot of run 1: fail stays sticky
        err_hi = 32'd0;
        err_lo = 32'd5;
        wait_sample("t2b");
        check("t2b_error_count", error_count, 64'd5);
        check("t2b_fail_sticky", 64'(fail), 64'd1);
        step();
        flush_writes();
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_write("t2b_disable", CSR_CTRL, 32'd0);
        check("t2b_idle", 64'(busy), 64'd0);

        // start and stop together in IDLE: no run
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("same_cycle_busy", 64'(busy), 64'd0);
        check("same_cycle_fail_kept", 64'(fail), 64'd1);

        // T3: threshold 5, equal does not fail, 6 does; start clears fail
        status_reads = 0;
        lock_after = 1;
        flush_writes();
        start_run(3'd6, 32'd5);
        check("t3_fail_cleared", 64'(fail), 64'd0);
        check("t3_locked_cleared", 64'(locked), 64'd0);
        expect_write("t3_patsel", CSR_PATSEL, 32'd6);
        wait_sample("t3a");
        check("t3a_error_count", error_count, 64'd5);
        check("t3a_no_fail_equal", 64'(fail), 64'd0);
        err_lo = 32'd6;
        step();
        wait_sample("t3b");
        check("t3b_error_count", error_count, 64'd6);
        check("t3b_fail_on_update", 64'(fail), 64'd1);
        check("t3b_fail_prev_cycle", 64'(prev_fail), 64'd0);
        step();
        check("t3b_fail_held", 64'(fail), 64'd1);

        // T4: stop while the ERR_HI read is in flight
        err_lo = 32'd7;
        sv_snap = sv_count;
        rd5_snap = rd_count[CSR_BITS_LO];
        n = 0;
        while (!(avm_read && avm_address == CSR_ERR_HI) && n < 100) begin step(); n++; end
        check("t4_rd_ehi_seen", 64'(avm_read && avm_address == CSR_ERR_HI), 64'd1);
        flush_writes();
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_write("t4_disable", CSR_CTRL, 32'd0);
        check("t4_busy_low", 64'(busy), 64'd0);
        check("t4_busy_timing", 64'(cyc - popped_cyc), 64'd1);
        check("t4_error_unchanged", error_count, 64'd6);
        check("t4_no_sample", 64'(sv_count - sv_snap), 64'd0);
        check("t4_no_bits_read", 64'(rd_count[CSR_BITS_LO] - rd5_snap), 64'd0);
        check("t4_fail_kept", 64'(fail), 64'd1);

        // T5: lock never asserted
        lock_after = 0;
        status_reads = 0;
        flush_writes();
        start_run(3'd1, 32'd0);
        repeat (1000) step();
`ifdef XCVR_CHK_SEQ_TIMEOUT_EN
        check("t5_lock_timeout", 64'(lock_timeout), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_disable_written", 64'(wq_data[wq_data.size()-1]), 64'd0);
`else
        check("t5_still_busy", 64'(busy), 64'd1);
        check("t5_no_timeout", 64'(lock_timeout), 64'd0);
        check("t5_not_locked", 64'(locked), 64'd0);
        check("t5_polling", 64'(status_reads > 100), 64'd1);
        flush_writes();
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_write("t5_disable", CSR_CTRL, 32'd0);
        check("t5_idle", 64'(busy), 64'd0);
`endif

        // T6: asynchronous reset during SNAP strobe
        lock_after = 1;
        status_reads = 0;
        err_lo = 32'd9;
        start_run(3'd2, 32'd100);
        n = 0;
        while (!(avm_write && avm_address == CSR_CTRL && avm_writedata == 32'd5) && n < 200) begin
            step();
            n++;
        end
        check("t6_snap_seen", 64'(avm_write && avm_writedata == 32'd5), 64'd1);
        #2;
        reset_reset = 1'b1;
        #1;
        check("t6_write_dropped", 64'(avm_write), 64'd0);
        check("t6_be_dropped", 64'(avm_byteenable), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_counts", {error_count[31:0], bit_count[31:0]}, 64'd0);
        check("t6_flags", 64'({sample_valid, fail, locked, lock_timeout}), 64'd0);
        step();
        reset_reset = 1'b0;
        step();
        flush_writes();
        start_run(3'd4, 32'd0);
        check("t6_restart_busy", 64'(busy), 64'd1);
        expect_write("t6_patsel", CSR_PATSEL, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
